// File: rtl/rr_arb_mux_if.sv
// Channel-side and downstream-side signals of the round-robin / fixed-select arbiter mux.
// Signal names follow the block's documented port list.
interface rr_arb_mux_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NCH   = 4
);
    localparam int unsigned SW = ($clog2(NCH) > 1) ? $clog2(NCH) : 1;

    logic [NCH*WIDTH-1:0] iDATA;
    logic [NCH-1:0]       iVALID;
    logic [NCH-1:0]       oREADY;
    logic                 iMODE;
    logic [SW-1:0]        iSEL;
    logic [WIDTH-1:0]     oDATA;
    logic                 oVALID;
    logic [SW-1:0]        oCH;
    logic                 iREADY;

    modport slave (
        input  iDATA, iVALID, iMODE, iSEL, iREADY,
        output oREADY, oDATA, oVALID, oCH
    );

    modport master (
        output iDATA, iVALID, iMODE, iSEL, iREADY,
        input  oREADY, oDATA, oVALID, oCH
    );
endinterface

// File: rtl/rr_arb_mux.sv
// N-channel arbiter mux: fixed-select or round-robin grant into a single registered
// output beat with a one-deep skid-free load rule (load = !oVALID || iREADY).
module rr_arb_mux #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NCH   = 4
) (
    input  logic         iCLK,
    input  logic         iRST,
    rr_arb_mux_if.slave  bus
);
    localparam int unsigned SW = ($clog2(NCH) > 1) ? $clog2(NCH) : 1;

    logic             load_c;
    logic             gnt_valid;
    logic [SW-1:0]    gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    logic [SW-1:0]    ptr_next;
    logic [NCH-1:0]   ready_c;

    logic [SW-1:0]    ptr;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic [SW-1:0]    ch_q;

    assign load_c = !valid_q || bus.iREADY;

    // Grant selection; fixed mode compares against every legal index so an
    // out-of-range iSEL simply matches nothing.
    always_comb begin
        logic [SW-1:0] idx;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        if (bus.iMODE) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                idx = SW'((32'(ptr) + i) % NCH);
                if (!gnt_valid && bus.iVALID[idx]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = idx;
                end
            end
        end else begin
            for (int unsigned k = 0; k < NCH; k++) begin
                if (bus.iSEL == SW'(k) && bus.iVALID[k]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = SW'(k);
                end
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (gnt_idx == SW'(k)) begin
                gnt_data = bus.iDATA[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        ready_c = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            ready_c[k] = !iRST && load_c && gnt_valid && (gnt_idx == SW'(k));
        end
    end

    assign ptr_next = (gnt_idx == SW'(NCH - 1)) ? '0 : gnt_idx + SW'(1);

    // Output beat register; pointer advances only on an actual transfer.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            ptr     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ch_q    <= '0;
        end else if (load_c) begin
            if (gnt_valid) begin
                data_q  <= gnt_data;
                ch_q    <= gnt_idx;
                valid_q <= 1'b1;
                ptr     <= ptr_next;
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.oREADY = ready_c;
    assign bus.oDATA  = data_q;
    assign bus.oVALID = valid_q;
    assign bus.oCH    = ch_q;
endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: cycle table on a 4-channel instance, async-reset
// sequence, and a 3-channel instance for out-of-range select and mod-3 wrap.
module tb_rr_arb_mux;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   row;

    rr_arb_mux_if #(.WIDTH(8), .NCH(4)) bus  ();
    rr_arb_mux_if #(.WIDTH(8), .NCH(3)) bus3 ();

    rr_arb_mux #(.WIDTH(8), .NCH(4)) dut  (.iCLK(clk), .iRST(rst), .bus(bus.slave));
    rr_arb_mux #(.WIDTH(8), .NCH(3)) dut3 (.iCLK(clk), .iRST(rst), .bus(bus3.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  valid;
        logic        rdy;
        logic [31:0] data;
        logic [3:0]  exp_ready;
        logic        exp_ov;
        logic [7:0]  exp_od;
        logic [1:0]  exp_och;
    } vec_t;

    localparam logic [31:0] D0 = {8'h44, 8'h33, 8'h22, 8'h11};
    localparam logic [31:0] D1 = {8'h44, 8'hA5, 8'h22, 8'h11};
    localparam int NV = 21;
    vec_t tbl [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (row %0d): got %h, expected %h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic mode, input logic [1:0] sel, input logic [3:0] valid,
                         input logic rdy, input logic [31:0] data);
        bus.iMODE  = mode;
        bus.iSEL   = sel;
        bus.iVALID = valid;
        bus.iREADY = rdy;
        bus.iDATA  = data;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        row   = -1;

        // cycle-by-cycle: inputs, combinational oREADY, registered outputs after the edge
        tbl[0]  = '{1'b1, 2'd0, 4'b1111, 1'b1, D0, 4'b0001, 1'b1, 8'h11, 2'd0};
        tbl[1]  = '{1'b1, 2'd0, 4'b1111, 1'b1, D0, 4'b0010, 1'b1, 8'h22, 2'd1};
        tbl[2]  = '{1'b1, 2'd0, 4'b1111, 1'b1, D0, 4'b0100, 1'b1, 8'h33, 2'd2};
        tbl[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, D0, 4'b1000, 1'b1, 8'h44, 2'd3};
        tbl[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, D0, 4'b0001, 1'b1, 8'h11, 2'd0};
        tbl[5]  = '{1'b1, 2'd0, 4'b1111, 1'b0, D0, 4'b0000, 1'b1, 8'h11, 2'd0};
        tbl[6]  = '{1'b1, 2'd0, 4'b1111, 1'b0, D0, 4'b0000, 1'b1, 8'h11, 2'd0};
        tbl[7]  = '{1'b1, 2'd0, 4'b1111, 1'b0, D0, 4'b0000, 1'b1, 8'h11, 2'd0};
        tbl[8]  = '{1'b1, 2'd0, 4'b1111, 1'b1, D0, 4'b0010, 1'b1, 8'h22, 2'd1};
        tbl[9]  = '{1'b1, 2'd0, 4'b0100, 1'b1, D0, 4'b0100, 1'b1, 8'h33, 2'd2};
        tbl[10] = '{1'b1, 2'd0, 4'b0011, 1'b1, D0, 4'b0001, 1'b1, 8'h11, 2'd0};
        tbl[11] = '{1'b1, 2'd0, 4'b0011, 1'b1, D0, 4'b0010, 1'b1, 8'h22, 2'd1};
        tbl[12] = '{1'b1, 2'd0, 4'b0011, 1'b1, D0, 4'b0001, 1'b1, 8'h11, 2'd0};
        tbl[13] = '{1'b0, 2'd2, 4'b0100, 1'b1, D1, 4'b0100, 1'b1, 8'hA5, 2'd2};
        tbl[14] = '{1'b0, 2'd2, 4'b0000, 1'b1, D1, 4'b0000, 1'b0, 8'hA5, 2'd2};
        tbl[15] = '{1'b0, 2'd1, 4'b1101, 1'b1, D0, 4'b0000, 1'b0, 8'hA5, 2'd2};
        tbl[16] = '{1'b1, 2'd1, 4'b1101, 1'b1, D0, 4'b1000, 1'b1, 8'h44, 2'd3};
        tbl[17] = '{1'b0, 2'd0, 4'b1111, 1'b0, D0, 4'b0000, 1'b1, 8'h44, 2'd3};
        tbl[18] = '{1'b0, 2'd0, 4'b1111, 1'b1, D0, 4'b0001, 1'b1, 8'h11, 2'd0};
        tbl[19] = '{1'b1, 2'd0, 4'b1111, 1'b1, D0, 4'b0010, 1'b1, 8'h22, 2'd1};
        tbl[20] = '{1'b1, 2'd0, 4'b0000, 1'b0, D0, 4'b0000, 1'b1, 8'h22, 2'd1};

        rst = 1'b1;
        drive(1'b1, 2'd0, 4'b1111, 1'b1, D0);
        bus3.iMODE = 1'b0; bus3.iSEL = '0; bus3.iVALID = '0; bus3.iREADY = 1'b1;
        bus3.iDATA = {8'h33, 8'h22, 8'h11};
        repeat (2) @(negedge clk);
        chk("reset_ovalid", 32'(bus.oVALID), 32'd0);
        chk("reset_odata",  32'(bus.oDATA),  32'd0);
        chk("reset_och",    32'(bus.oCH),    32'd0);
        chk("reset_oready", 32'(bus.oREADY), 32'd0);

        drive(1'b1, 2'd0, 4'b0000, 1'b1, D0);
        #1 rst = 1'b0;

        for (int r = 0; r < NV; r++) begin
            row = r;
            @(negedge clk);
            drive(tbl[r].mode, tbl[r].sel, tbl[r].valid, tbl[r].rdy, tbl[r].data);
            #1 chk("oready", 32'(bus.oREADY), 32'(tbl[r].exp_ready));
            @(posedge clk);
            #1;
            chk("ovalid", 32'(bus.oVALID), 32'(tbl[r].exp_ov));
            chk("odata",  32'(bus.oDATA),  32'(tbl[r].exp_od));
            chk("och",    32'(bus.oCH),    32'(tbl[r].exp_och));
        end

        // async reset between edges with a held beat and a nonzero pointer
        row = 100;
        @(negedge clk);
        drive(1'b1, 2'd0, 4'b1111, 1'b1, D0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ovalid", 32'(bus.oVALID), 32'd0);
        chk("async_rst_odata",  32'(bus.oDATA),  32'd0);
        chk("async_rst_och",    32'(bus.oCH),    32'd0);
        chk("async_rst_oready", 32'(bus.oREADY), 32'd0);
        @(posedge clk);
        #1 chk("rst_hold_ovalid", 32'(bus.oVALID), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post_rst_oready", 32'(bus.oREADY), 32'b0001);
        @(posedge clk);
        #1;
        chk("post_rst_odata", 32'(bus.oDATA), 32'h11);
        chk("post_rst_och",   32'(bus.oCH),   32'd0);
        chk("post_rst_ovalid", 32'(bus.oVALID), 32'd1);

        // 3-channel instance: iSEL = 3 is out of range, then wrap of the pointer mod 3
        row = 200;
        @(negedge clk);
        drive(1'b1, 2'd0, 4'b0000, 1'b1, D0);
        bus3.iMODE = 1'b0; bus3.iSEL = 2'd3; bus3.iVALID = 3'b111;
        #1 chk("n3_sel3_oready", 32'(bus3.oREADY), 32'd0);
        @(posedge clk);
        #1 chk("n3_sel3_ovalid", 32'(bus3.oVALID), 32'd0);
        @(negedge clk);
        bus3.iSEL = 2'd2;
        #1 chk("n3_sel2_oready", 32'(bus3.oREADY), 32'b100);
        @(posedge clk);
        #1;
        chk("n3_sel2_odata", 32'(bus3.oDATA), 32'h33);
        chk("n3_sel2_och",   32'(bus3.oCH),   32'd2);
        @(negedge clk);
        bus3.iMODE = 1'b1;
        #1 chk("n3_wrap_oready", 32'(bus3.oREADY), 32'b001);
        @(posedge clk);
        #1;
        chk("n3_wrap_odata", 32'(bus3.oDATA), 32'h11);
        chk("n3_wrap_och",   32'(bus3.oCH),   32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
